// File: rtl/dcache_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : dcache_mem_responder_if
// Purpose : Bundles the cache-side request/response signals and the
//           backing-memory port of dcache_mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
interface dcache_mem_responder_if #(
    parameter int TAG_BITS     = 51,
    parameter int INDEX_BITS   = 8,
    parameter int LINE_BITS    = 256,
    parameter int ST_ADDR_BITS = 64
);
    logic [TAG_BITS+INDEX_BITS-1:0] dc2memLdAddr_i;
    logic                           dc2memLdValid_i;
    logic                           dc2memLdIsReserve_i;
    logic [TAG_BITS-1:0]            mem2dcLdTag_o;
    logic [INDEX_BITS-1:0]          mem2dcLdIndex_o;
    logic [LINE_BITS-1:0]           mem2dcLdData_o;
    logic                           mem2dcLdValid_o;

    logic [ST_ADDR_BITS-1:0]        dc2memStAddr_i;
    logic [63:0]                    dc2memStData_i;
    logic [2:0]                     dc2memStSize_i;
    logic                           dc2memStValid_i;
    logic                           mem2dcStComplete_o;
    logic                           mem2dcStStall_o;

    logic                           extInv_i;
    logic [INDEX_BITS-1:0]          extInvIndex_i;
    logic                           mem2dcInv_o;
    logic [INDEX_BITS-1:0]          mem2dcInvInd_o;
    logic                           mem2dcInvWay_o;

    logic                           memReq_o;
    logic                           memWe_o;
    logic [63:0]                    memAddr_o;
    logic [63:0]                    memWrData_o;
    logic [7:0]                     memByteEn_o;
    logic                           memGnt_i;
    logic                           memRdValid_i;
    logic [63:0]                    memRdData_i;

    logic                           resValid_o;
    logic [TAG_BITS+INDEX_BITS-1:0] resAddr_o;
    logic                           ldOverflow_o;
    logic                           stOverflow_o;

    modport slave (
        input  dc2memLdAddr_i, dc2memLdValid_i, dc2memLdIsReserve_i,
        input  dc2memStAddr_i, dc2memStData_i, dc2memStSize_i, dc2memStValid_i,
        input  extInv_i, extInvIndex_i,
        input  memGnt_i, memRdValid_i, memRdData_i,
        output mem2dcLdTag_o, mem2dcLdIndex_o, mem2dcLdData_o, mem2dcLdValid_o,
        output mem2dcStComplete_o, mem2dcStStall_o,
        output mem2dcInv_o, mem2dcInvInd_o, mem2dcInvWay_o,
        output memReq_o, memWe_o, memAddr_o, memWrData_o, memByteEn_o,
        output resValid_o, resAddr_o, ldOverflow_o, stOverflow_o
    );

    modport master (
        output dc2memLdAddr_i, dc2memLdValid_i, dc2memLdIsReserve_i,
        output dc2memStAddr_i, dc2memStData_i, dc2memStSize_i, dc2memStValid_i,
        output extInv_i, extInvIndex_i,
        output memGnt_i, memRdValid_i, memRdData_i,
        input  mem2dcLdTag_o, mem2dcLdIndex_o, mem2dcLdData_o, mem2dcLdValid_o,
        input  mem2dcStComplete_o, mem2dcStStall_o,
        input  mem2dcInv_o, mem2dcInvInd_o, mem2dcInvWay_o,
        input  memReq_o, memWe_o, memAddr_o, memWrData_o, memByteEn_o,
        input  resValid_o, resAddr_o, ldOverflow_o, stOverflow_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dcache_mem_responder
// Purpose : Services L1D line fills and write-through stores against a 64-bit
//           backing memory; forwards invalidations and tracks an LR reservation.
// Rev     : 1.0  initial release
// ============================================================================
module dcache_mem_responder #(
    parameter int TAG_BITS     = 51,
    parameter int INDEX_BITS   = 8,
    parameter int LINE_BITS    = 256,
    parameter int ST_ADDR_BITS = 64,
    parameter int LDQ_DEPTH    = 4,
    parameter int STQ_DEPTH    = 4
) (
    input wire                     clk,
    input wire                     reset,
    dcache_mem_responder_if.slave  bus
);
    localparam int c_BLK_BITS  = TAG_BITS + INDEX_BITS;
    localparam int c_BEATS     = LINE_BITS / 64;
    localparam int c_BEAT_BITS = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_LDQ_AW    = $clog2(LDQ_DEPTH);
    localparam int c_STQ_AW    = $clog2(STQ_DEPTH);
    localparam logic [c_BEAT_BITS-1:0] c_LAST_BEAT = c_BEAT_BITS'(c_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ST_WR   = 3'd1,
        S_LD_REQ  = 3'd2,
        S_LD_WAIT = 3'd3,
        S_LD_RESP = 3'd4
    } state_t;

    state_t                   r_state, w_state_next;
    logic [c_BEAT_BITS-1:0]   r_beat, w_beat_next;

    // ---------------- load request queue ----------------
    logic [c_BLK_BITS-1:0]    r_ldq_addr [LDQ_DEPTH];
    logic                     r_ldq_rsv  [LDQ_DEPTH];
    logic [c_LDQ_AW-1:0]      r_ldq_rd, r_ldq_wr;
    logic [c_LDQ_AW:0]        r_ldq_cnt;
    logic                     w_ldq_full, w_ldq_push, w_ldq_pop;
    logic [c_BLK_BITS-1:0]    w_ld_blk;
    logic                     w_ld_rsv;
    logic                     r_ld_ovf;

    assign w_ldq_full = (r_ldq_cnt == (c_LDQ_AW+1)'(LDQ_DEPTH));
    assign w_ldq_pop  = (r_state == S_LD_RESP);
    assign w_ldq_push = bus.dc2memLdValid_i && (!w_ldq_full || w_ldq_pop);
    assign w_ld_blk   = r_ldq_addr[r_ldq_rd];
    assign w_ld_rsv   = r_ldq_rsv[r_ldq_rd];

    always_ff @(posedge clk) begin
        if (w_ldq_push) begin
            r_ldq_addr[r_ldq_wr] <= bus.dc2memLdAddr_i;
            r_ldq_rsv[r_ldq_wr]  <= bus.dc2memLdIsReserve_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ldq_rd  <= '0;
            r_ldq_wr  <= '0;
            r_ldq_cnt <= '0;
            r_ld_ovf  <= 1'b0;
        end else begin
            if (w_ldq_push) r_ldq_wr <= r_ldq_wr + c_LDQ_AW'(1);
            if (w_ldq_pop)  r_ldq_rd <= r_ldq_rd + c_LDQ_AW'(1);
            case ({w_ldq_push, w_ldq_pop})
                2'b10:   r_ldq_cnt <= r_ldq_cnt + (c_LDQ_AW+1)'(1);
                2'b01:   r_ldq_cnt <= r_ldq_cnt - (c_LDQ_AW+1)'(1);
                default: r_ldq_cnt <= r_ldq_cnt;
            endcase
            if (bus.dc2memLdValid_i && !w_ldq_push) r_ld_ovf <= 1'b1;
        end
    end

    // ---------------- store queue ----------------
    logic [ST_ADDR_BITS-1:0]  r_stq_addr [STQ_DEPTH];
    logic [63:0]              r_stq_data [STQ_DEPTH];
    logic [2:0]               r_stq_size [STQ_DEPTH];
    logic [c_STQ_AW-1:0]      r_stq_rd, r_stq_wr;
    logic [c_STQ_AW:0]        r_stq_cnt;
    logic                     w_stq_full, w_stq_push, w_stq_pop;
    logic [ST_ADDR_BITS-1:0]  w_st_addr;
    logic [63:0]              w_st_data;
    logic [2:0]               w_st_size;
    logic                     r_st_ovf;

    assign w_stq_full = (r_stq_cnt == (c_STQ_AW+1)'(STQ_DEPTH));
    assign w_stq_pop  = (r_state == S_ST_WR) && bus.memGnt_i;
    assign w_stq_push = bus.dc2memStValid_i && (!w_stq_full || w_stq_pop);
    assign w_st_addr  = r_stq_addr[r_stq_rd];
    assign w_st_data  = r_stq_data[r_stq_rd];
    assign w_st_size  = r_stq_size[r_stq_rd];

    always_ff @(posedge clk) begin
        if (w_stq_push) begin
            r_stq_addr[r_stq_wr] <= bus.dc2memStAddr_i;
            r_stq_data[r_stq_wr] <= bus.dc2memStData_i;
            r_stq_size[r_stq_wr] <= bus.dc2memStSize_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stq_rd  <= '0;
            r_stq_wr  <= '0;
            r_stq_cnt <= '0;
            r_st_ovf  <= 1'b0;
        end else begin
            if (w_stq_push) r_stq_wr <= r_stq_wr + c_STQ_AW'(1);
            if (w_stq_pop)  r_stq_rd <= r_stq_rd + c_STQ_AW'(1);
            case ({w_stq_push, w_stq_pop})
                2'b10:   r_stq_cnt <= r_stq_cnt + (c_STQ_AW+1)'(1);
                2'b01:   r_stq_cnt <= r_stq_cnt - (c_STQ_AW+1)'(1);
                default: r_stq_cnt <= r_stq_cnt;
            endcase
            if (bus.dc2memStValid_i && !w_stq_push) r_st_ovf <= 1'b1;
        end
    end

    // ---------------- store lane formatting ----------------
    logic [2:0]  w_lane;
    logic [7:0]  w_st_be;
    logic [63:0] w_st_wdata;

    assign w_lane = w_st_addr[2:0];

    always_comb begin
        w_st_be    = 8'h00;
        w_st_wdata = 64'd0;
        case (w_st_size)
            3'd0: w_st_be = 8'h01 << w_lane;
            3'd1: w_st_be = 8'h03 << {w_lane[2:1], 1'b0};
            3'd2: w_st_be = w_lane[2] ? 8'hF0 : 8'h0F;
            3'd3: w_st_be = 8'hFF;
            default: w_st_be = 8'h00;
        endcase
        // Illegal sizes still retire, but write nothing.
        if (!w_st_size[2]) w_st_wdata = w_st_data << {w_lane, 3'b000};
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        case (r_state)
            S_IDLE: begin
                // Stores first so a fill always sees every earlier store.
                if (r_stq_cnt != '0) begin
                    w_state_next = S_ST_WR;
                end else if (r_ldq_cnt != '0) begin
                    w_state_next = S_LD_REQ;
                    w_beat_next  = '0;
                end
            end
            S_ST_WR:   if (bus.memGnt_i) w_state_next = S_IDLE;
            S_LD_REQ:  if (bus.memGnt_i) w_state_next = S_LD_WAIT;
            S_LD_WAIT: begin
                if (bus.memRdValid_i) begin
                    if (r_beat == c_LAST_BEAT) begin
                        w_state_next = S_LD_RESP;
                    end else begin
                        w_state_next = S_LD_REQ;
                        w_beat_next  = r_beat + c_BEAT_BITS'(1);
                    end
                end
            end
            S_LD_RESP: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.memReq_o    = 1'b0;
        bus.memWe_o     = 1'b0;
        bus.memAddr_o   = 64'd0;
        bus.memWrData_o = 64'd0;
        bus.memByteEn_o = 8'h00;
        case (r_state)
            S_ST_WR: begin
                bus.memReq_o    = 1'b1;
                bus.memWe_o     = 1'b1;
                bus.memAddr_o   = 64'({w_st_addr[ST_ADDR_BITS-1:3], 3'b000});
                bus.memWrData_o = w_st_wdata;
                bus.memByteEn_o = w_st_be;
            end
            S_LD_REQ: begin
                bus.memReq_o  = 1'b1;
                bus.memAddr_o = 64'({w_ld_blk, r_beat, 3'b000});
            end
            default: ;
        endcase
    end

    // ---------------- fill assembly and line return ----------------
    logic [LINE_BITS-1:0]  r_line, w_line_next;
    logic                  w_beat_take, w_last_take;
    logic                  r_ld_valid;
    logic [TAG_BITS-1:0]   r_ld_tag;
    logic [INDEX_BITS-1:0] r_ld_index;
    logic [LINE_BITS-1:0]  r_ld_data;

    assign w_beat_take = (r_state == S_LD_WAIT) && bus.memRdValid_i;
    assign w_last_take = w_beat_take && (r_beat == c_LAST_BEAT);

    always_comb begin
        w_line_next = r_line;
        w_line_next[64*r_beat +: 64] = bus.memRdData_i;
    end

    // Return registers load on the final beat so the strobe lands in LD_RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line     <= '0;
            r_ld_valid <= 1'b0;
            r_ld_tag   <= '0;
            r_ld_index <= '0;
            r_ld_data  <= '0;
        end else begin
            r_ld_valid <= w_last_take;
            if (w_beat_take) r_line <= w_line_next;
            if (w_last_take) begin
                r_ld_tag   <= w_ld_blk[c_BLK_BITS-1:INDEX_BITS];
                r_ld_index <= w_ld_blk[INDEX_BITS-1:0];
                r_ld_data  <= w_line_next;
            end
        end
    end

    // ---------------- reservation, completion, invalidation ----------------
    logic                  r_res_valid;
    logic [c_BLK_BITS-1:0] r_res_addr;
    logic                  w_res_hit;
    logic                  r_st_done;
    logic                  r_inv;
    logic [INDEX_BITS-1:0] r_inv_ind;

    assign w_res_hit = (ST_ADDR_BITS'(w_st_addr >> 5) == ST_ADDR_BITS'(r_res_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_addr  <= '0;
            r_st_done   <= 1'b0;
            r_inv       <= 1'b0;
            r_inv_ind   <= '0;
        end else begin
            r_st_done <= w_stq_pop;
            r_inv     <= bus.extInv_i;
            r_inv_ind <= bus.extInvIndex_i;
            if (w_ldq_pop && w_ld_rsv) begin
                r_res_valid <= 1'b1;
                r_res_addr  <= w_ld_blk;
            end else if (w_stq_pop && w_res_hit) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.mem2dcLdValid_o    = r_ld_valid;
    assign bus.mem2dcLdTag_o      = r_ld_tag;
    assign bus.mem2dcLdIndex_o    = r_ld_index;
    assign bus.mem2dcLdData_o     = r_ld_data;
    assign bus.mem2dcStComplete_o = r_st_done;
    assign bus.mem2dcStStall_o    = (r_stq_cnt >= (c_STQ_AW+1)'(STQ_DEPTH - 1));
    assign bus.mem2dcInv_o        = r_inv;
    assign bus.mem2dcInvInd_o     = r_inv_ind;
    assign bus.mem2dcInvWay_o     = 1'b0;
    assign bus.resValid_o         = r_res_valid;
    assign bus.resAddr_o          = r_res_addr;
    assign bus.ldOverflow_o       = r_ld_ovf;
    assign bus.stOverflow_o       = r_st_ovf;
endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_mem_responder
// Purpose : Directed stimulus with a queue-level reference model for
//           dcache_mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dcache_mem_responder;
    localparam int TAG_BITS = 51, INDEX_BITS = 8, LINE_BITS = 256, ST_ADDR_BITS = 64;
    localparam int LDQ_DEPTH = 4, STQ_DEPTH = 4;
    localparam int BLK_BITS = TAG_BITS + INDEX_BITS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dcache_mem_responder_if #(.TAG_BITS(TAG_BITS), .INDEX_BITS(INDEX_BITS),
        .LINE_BITS(LINE_BITS), .ST_ADDR_BITS(ST_ADDR_BITS)) bus ();

    dcache_mem_responder #(.TAG_BITS(TAG_BITS), .INDEX_BITS(INDEX_BITS),
        .LINE_BITS(LINE_BITS), .ST_ADDR_BITS(ST_ADDR_BITS),
        .LDQ_DEPTH(LDQ_DEPTH), .STQ_DEPTH(STQ_DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory content: beat k of block b reads as (b<<8) + 0xA0 + k.
    function automatic logic [63:0] pat(input logic [63:0] a);
        return 64'hA0 + 64'(a[4:3]) + ((a >> 5) << 8);
    endfunction

    function automatic logic [255:0] exp_line(input logic [BLK_BITS-1:0] b);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = pat({b, 2'(k), 3'b000});
        return l;
    endfunction

    function automatic logic [7:0] exp_be(input logic [63:0] a, input logic [2:0] sz);
        int nb, off;
        if (sz > 3'd3) return 8'h00;
        nb  = 1 << sz;
        off = (int'(a[2:0]) / nb) * nb;
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [63:0] exp_wd(input logic [63:0] a, input logic [63:0] d, input logic [2:0] sz);
        if (sz > 3'd3) return 64'd0;
        return d << (8 * int'(a[2:0]));
    endfunction

    // ---------------- backing memory ----------------
    logic gnt_en = 1'b1;
    logic late_rd = 1'b0;
    initial begin
        logic        grab;
        logic [63:0] a;
        bus.memGnt_i = 1'b1;
        bus.memRdValid_i = 1'b0;
        bus.memRdData_i = 64'd0;
        forever begin
            @(negedge clk);
            grab = bus.memReq_o && !bus.memWe_o && bus.memGnt_i;
            a = bus.memAddr_o;
            @(posedge clk); #1;
            bus.memGnt_i = gnt_en;
            bus.memRdValid_i = grab || late_rd;
            bus.memRdData_i = grab ? pat(a) : 64'd0;
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    typedef struct { logic [BLK_BITS-1:0] blk; logic rsv; } ld_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; logic [2:0] size; } st_t;
    ld_t m_ld[$];
    st_t m_st[$];
    int m_beat;
    logic m_res_v, m_ldovf, m_stovf, m_cmp, m_inv;
    logic [BLK_BITS-1:0] m_res_a;
    logic [INDEX_BITS-1:0] m_inv_ind;

    initial begin
        logic st_pop, ld_pop;
        logic [63:0] ea;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ld.delete(); m_st.delete();
                m_beat = 0; m_res_v = 0; m_res_a = '0; m_ldovf = 0; m_stovf = 0;
                m_cmp = 0; m_inv = 0; m_inv_ind = '0;
                continue;
            end
            check("stall", bus.mem2dcStStall_o, m_st.size() >= STQ_DEPTH - 1);
            check("st_ovf", bus.stOverflow_o, m_stovf);
            check("ld_ovf", bus.ldOverflow_o, m_ldovf);
            check("res_valid", bus.resValid_o, m_res_v);
            if (m_res_v) check("res_addr", bus.resAddr_o, m_res_a);
            check("st_complete", bus.mem2dcStComplete_o, m_cmp);
            check("inv", bus.mem2dcInv_o, m_inv);
            if (m_inv) check("inv_ind", bus.mem2dcInvInd_o, m_inv_ind);
            check("inv_way", bus.mem2dcInvWay_o, 1'b0);
            if (bus.memReq_o && bus.memWe_o) begin
                if (m_st.size() == 0) check("st_write_unexpected", 1'b1, 1'b0);
                else begin
                    check("st_addr", bus.memAddr_o, m_st[0].addr & ~64'h7);
                    check("st_be", bus.memByteEn_o, exp_be(m_st[0].addr, m_st[0].size));
                    check("st_wdata", bus.memWrData_o, exp_wd(m_st[0].addr, m_st[0].data, m_st[0].size));
                end
            end
            if (bus.memReq_o && !bus.memWe_o) begin
                if (m_ld.size() == 0) check("ld_read_unexpected", 1'b1, 1'b0);
                else begin
                    ea = {m_ld[0].blk, 2'(m_beat), 3'b000};
                    check("ld_raddr", bus.memAddr_o, ea);
                end
            end
            if (bus.mem2dcLdValid_o) begin
                if (m_ld.size() == 0) check("ld_ret_unexpected", 1'b1, 1'b0);
                else begin
                    check("ld_tag", bus.mem2dcLdTag_o, m_ld[0].blk[BLK_BITS-1:INDEX_BITS]);
                    check("ld_index", bus.mem2dcLdIndex_o, m_ld[0].blk[INDEX_BITS-1:0]);
                    check("ld_data", bus.mem2dcLdData_o, exp_line(m_ld[0].blk));
                end
            end
            st_pop = bus.memReq_o && bus.memWe_o && bus.memGnt_i && (m_st.size() > 0);
            m_cmp = st_pop;
            if (st_pop) begin
                if (m_res_v && ((m_st[0].addr >> 5) == 64'(m_res_a))) m_res_v = 0;
                void'(m_st.pop_front());
            end
            if (bus.memRdValid_i && m_ld.size() > 0) m_beat++;
            ld_pop = bus.mem2dcLdValid_o && (m_ld.size() > 0);
            if (ld_pop) begin
                if (m_ld[0].rsv) begin m_res_v = 1; m_res_a = m_ld[0].blk; end
                void'(m_ld.pop_front());
                m_beat = 0;
            end
            if (bus.dc2memStValid_i) begin
                if (m_st.size() < STQ_DEPTH || st_pop)
                    m_st.push_back('{bus.dc2memStAddr_i, bus.dc2memStData_i, bus.dc2memStSize_i});
                else m_stovf = 1;
            end
            if (bus.dc2memLdValid_i) begin
                if (m_ld.size() < LDQ_DEPTH || ld_pop)
                    m_ld.push_back('{bus.dc2memLdAddr_i, bus.dc2memLdIsReserve_i});
                else m_ldovf = 1;
            end
            m_inv = bus.extInv_i;
            m_inv_ind = bus.extInvIndex_i;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic drive_ld(input logic [BLK_BITS-1:0] b, input logic rsv);
        bus.dc2memLdValid_i = 1'b1; bus.dc2memLdAddr_i = b; bus.dc2memLdIsReserve_i = rsv;
    endtask

    task automatic drive_st(input logic [63:0] a, input logic [63:0] d, input logic [2:0] sz);
        bus.dc2memStValid_i = 1'b1; bus.dc2memStAddr_i = a; bus.dc2memStData_i = d; bus.dc2memStSize_i = sz;
    endtask

    // which: 0 = line return, 1 = store write request, 2 = store complete
    task automatic wait_for(input int which, input int limit, output int n, output bit found);
        logic s;
        n = 1; found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (which)
                0: s = bus.mem2dcLdValid_o;
                1: s = bus.memReq_o && bus.memWe_o;
                default: s = bus.mem2dcStComplete_o;
            endcase
            if (s) begin found = 1; break; end
            n++;
        end
        if (!found) check("wait_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int n, cnt, cmp_cyc, rd_cyc;
        bit found;
        logic [BLK_BITS-1:0] blk_b;
        bus.dc2memLdValid_i = 0; bus.dc2memLdAddr_i = '0; bus.dc2memLdIsReserve_i = 0;
        bus.dc2memStValid_i = 0; bus.dc2memStAddr_i = '0; bus.dc2memStData_i = '0; bus.dc2memStSize_i = '0;
        bus.extInv_i = 0; bus.extInvIndex_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_memreq", bus.memReq_o, 1'b0);
        check("rst_ldvalid", bus.mem2dcLdValid_o, 1'b0);
        check("rst_stall", bus.mem2dcStStall_o, 1'b0);
        check("rst_res", bus.resValid_o, 1'b0);
        check("rst_ovf", {bus.ldOverflow_o, bus.stOverflow_o}, 2'b00);

        // single fill of block 0x123
        next(); drive_ld(59'h123, 1'b0);
        next(); bus.dc2memLdValid_i = 0;
        wait_for(0, 40, n, found);
        if (found) begin
            check("fill_latency", n, 10);
            check("fill_data", bus.mem2dcLdData_o,
                  {64'h123A3, 64'h123A2, 64'h123A1, 64'h123A0});
            check("fill_tag", bus.mem2dcLdTag_o, 51'h1);
            check("fill_index", bus.mem2dcLdIndex_o, 8'h23);
        end

        // byte store
        next(); drive_st(64'h1005, 64'hEE, 3'd0);
        next(); bus.dc2memStValid_i = 0;
        wait_for(1, 20, n, found);
        if (found) begin
            check("byte_st_latency", n, 2);
            check("byte_st_be", bus.memByteEn_o, 8'h20);
            check("byte_st_data", bus.memWrData_o, 64'h0000_EE00_0000_0000);
            check("byte_st_addr", bus.memAddr_o, 64'h1000);
        end
        @(negedge clk); check("byte_st_cmp", bus.mem2dcStComplete_o, 1'b1);
        @(negedge clk); check("byte_st_cmp_once", bus.mem2dcStComplete_o, 1'b0);

        // word store
        next(); drive_st(64'h1004, 64'h11223344, 3'd2);
        next(); bus.dc2memStValid_i = 0;
        wait_for(1, 20, n, found);
        if (found) begin
            check("word_st_be", bus.memByteEn_o, 8'hF0);
            check("word_st_data", bus.memWrData_o, 64'h1122_3344_0000_0000);
        end
        wait_for(2, 20, n, found);

        // store priority over a simultaneous fill
        next(); drive_ld(59'h456, 1'b0); drive_st(64'h2000, 64'h55, 3'd3);
        next(); bus.dc2memLdValid_i = 0; bus.dc2memStValid_i = 0;
        cmp_cyc = -1; rd_cyc = -1;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem2dcStComplete_o && cmp_cyc < 0) cmp_cyc = i;
            if (bus.memReq_o && !bus.memWe_o && rd_cyc < 0) rd_cyc = i;
            if (bus.mem2dcLdValid_o) break;
        end
        check("prio_cmp_cycle", cmp_cyc, 3);
        check("prio_rd_cycle", rd_cyc, 4);

        // store back-pressure and overflow
        gnt_en = 0; next(); next();
        for (int k = 0; k < 5; k++) begin
            next(); drive_st(64'h3000 + 64'(8 * k), 64'(k + 1), 3'd3);
            @(negedge clk);
            if (k == 2) check("stall_cnt2", bus.mem2dcStStall_o, 1'b0);
            if (k == 3) check("stall_cnt3", bus.mem2dcStStall_o, 1'b1);
        end
        next(); bus.dc2memStValid_i = 0;
        @(negedge clk); check("st_overflow", bus.stOverflow_o, 1'b1);
        gnt_en = 1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.mem2dcStComplete_o) cnt++;
        end
        check("bp_completes", cnt, 4);

        // load queue overflow
        gnt_en = 0; next(); next();
        for (int k = 0; k < 5; k++) begin
            next(); drive_ld(59'h500 + 59'(k), 1'b0);
        end
        next(); bus.dc2memLdValid_i = 0;
        @(negedge clk); check("ld_overflow", bus.ldOverflow_o, 1'b1);
        gnt_en = 1; cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mem2dcLdValid_o) cnt++;
        end
        check("ldovf_fills", cnt, 4);

        // reservation set / kept / cleared
        blk_b = 59'h2ABCD;
        next(); drive_ld(blk_b, 1'b1);
        next(); bus.dc2memLdValid_i = 0;
        wait_for(0, 40, n, found);
        @(negedge clk);
        check("res_set", bus.resValid_o, 1'b1);
        check("res_set_addr", bus.resAddr_o, blk_b);
        next(); drive_st(64'h1000, 64'h1, 3'd3);
        next(); bus.dc2memStValid_i = 0;
        wait_for(2, 20, n, found);
        @(negedge clk); check("res_kept", bus.resValid_o, 1'b1);
        next(); drive_st({blk_b, 5'b0} + 64'd8, 64'h2, 3'd3);
        next(); bus.dc2memStValid_i = 0;
        wait_for(2, 20, n, found);
        @(negedge clk); check("res_cleared", bus.resValid_o, 1'b0);

        // invalidation forwarding
        next(); bus.extInv_i = 1; bus.extInvIndex_i = 8'd5;
        next(); bus.extInvIndex_i = 8'd7;
        @(negedge clk); check("inv_a", {bus.mem2dcInv_o, bus.mem2dcInvInd_o}, {1'b1, 8'd5});
        next(); bus.extInv_i = 0;
        @(negedge clk); check("inv_b", {bus.mem2dcInv_o, bus.mem2dcInvInd_o}, {1'b1, 8'd7});
        next();
        @(negedge clk); check("inv_off", bus.mem2dcInv_o, 1'b0);

        // asynchronous reset in the middle of a fill
        next(); drive_ld(59'h77, 1'b1);
        next(); bus.dc2memLdValid_i = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.memReq_o && !bus.memWe_o && bus.memAddr_o[4:3] == 2'd2 && bus.memGnt_i) begin
                found = 1; break;
            end
        end
        check("beat2_seen", found, 1'b1);
        @(posedge clk); #2 reset = 1'b1; #1;
        check("arst_memreq", bus.memReq_o, 1'b0);
        check("arst_ldvalid", bus.mem2dcLdValid_o, 1'b0);
        check("arst_ovf", {bus.ldOverflow_o, bus.stOverflow_o}, 2'b00);
        check("arst_data", bus.mem2dcLdData_o, 256'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; late_rd = 1'b1;
        @(posedge clk); #2 late_rd = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem2dcLdValid_o || bus.memReq_o) cnt++;
        end
        check("post_reset_quiet", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
